// File: rtl/nm_complement_seq.sv
// nm_complement_seq: multi-cycle conditional two's-complementer.
// Converts one operand per transaction, DIGIT bits per cycle, with a
// carry register between cycles. Modes: 00 pass, 01 negate, 10 abs,
// 11 sign-magnitude to two's complement.
// Optional build macro NM_COMPLEMENT_SAT_EN: saturate the overflow case
// to the maximum positive value instead of wrapping.
module nm_complement_seq #(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_parallel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_pos,
    output logic             sign_out,
    output logic             ovf
);

    localparam int unsigned NCHUNK = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int unsigned PW     = NCHUNK * DIGIT;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [CW-1:0]    LAST_CNT = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef NM_COMPLEMENT_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   op_q, op_d;      // operand, shifted right one digit per cycle
    logic [PW-1:0]   acc_q, acc_d;    // result, filled from the top one digit per cycle
    logic            inv_q, inv_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic            ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic            inv_new;
    logic [DIGIT-1:0] slice;
    logic [DIGIT:0]   sum;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        inv_d       = inv_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        inv_new     = (mode == 2'b01) | (mode[1] & x_parallel[WIDTH-1]);
        slice       = op_q[DIGIT-1:0] ^ {DIGIT{inv_q}};
        sum         = {1'b0, slice} + (DIGIT+1)'(carry_q);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d  = x_parallel[WIDTH-1];
                    ovf_d   = ((mode == 2'b01) || (mode == 2'b10)) && (x_parallel == MOST_NEG);
                    op_d    = PW'(x_parallel);
                    // Sign-magnitude: only the magnitude is converted
                    if (mode == 2'b11) begin
                        op_d[WIDTH-1] = 1'b0;
                    end
                    inv_d   = inv_new;
                    carry_d = inv_new;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = (acc_q >> DIGIT) | (PW'(sum[DIGIT-1:0]) << (PW - DIGIT));
                op_d    = op_q >> DIGIT;
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
`ifdef NM_COMPLEMENT_SAT_EN
                    if (ovf_q) begin
                        acc_d = PW'(MAX_POS);
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            inv_q       <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            inv_q       <= inv_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_pos     = acc_q[WIDTH-1:0];
    assign sign_out  = sign_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nm_complement_seq.sv
// Testbench for nm_complement_seq: scoreboard on the default instance,
// directed latency/value checks on two extra parameterisations.
module tb_nm_complement_seq;

    localparam int unsigned W  = 23;
    localparam int unsigned NC = 3;
    localparam logic [W-1:0] MNEG = {1'b1, {(W-1){1'b0}}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, sign_out, ovf;
    logic [W-1:0] x_in, x_pos;
    logic [1:0]   mode_in;

    logic         a_iv, a_ir, a_ov, a_s, a_ovf;
    logic [7:0]   a_x, a_xp;
    logic [1:0]   a_m;
    logic         b_iv, b_ir, b_ov, b_s, b_ovf;
    logic [31:0]  b_x, b_xp;
    logic [1:0]   b_m;

    nm_complement_seq #(.WIDTH(23), .DIGIT(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_parallel(x_in), .mode(mode_in), .out_valid(out_valid),
        .out_ready(out_ready), .x_pos(x_pos), .sign_out(sign_out), .ovf(ovf));

    nm_complement_seq #(.WIDTH(8), .DIGIT(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
        .x_parallel(a_x), .mode(a_m), .out_valid(a_ov),
        .out_ready(1'b1), .x_pos(a_xp), .sign_out(a_s), .ovf(a_ovf));

    nm_complement_seq #(.WIDTH(32), .DIGIT(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
        .x_parallel(b_x), .mode(b_m), .out_valid(b_ov),
        .out_ready(1'b1), .x_pos(b_xp), .sign_out(b_s), .ovf(b_ovf));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int bp     = 0;   // 0: out_ready=1, 1: random, 2: manual

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        sgn;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    logic seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: plain modular arithmetic on the operand. Returns {ovf, sign, result}.
    function automatic logic [65:0] ref_model(input logic [63:0] x, input logic [1:0] m, input int w);
        logic [63:0] mask, msb, mag, res;
        logic        sgn, ov;
        mask = (64'd1 << w) - 64'd1;
        msb  = 64'd1 << (w - 1);
        sgn  = (x & msb) != 64'd0;
        mag  = x & ~msb;
        case (m)
            2'b00:   res = x;
            2'b01:   res = (64'd0 - x) & mask;
            2'b10:   res = sgn ? ((64'd0 - x) & mask) : x;
            default: res = sgn ? ((64'd0 - mag) & mask) : mag;
        endcase
        ov = ((m == 2'b01) || (m == 2'b10)) && (x == msb);
`ifdef NM_COMPLEMENT_SAT_EN
        if (ov) res = msb - 64'd1;
`endif
        return {ov, sgn, res};
    endfunction

    // out_ready driver
    always @(posedge clk) begin
        #1;
        if (bp == 0) out_ready = 1'b1;
        else if (bp == 1) out_ready = 1'($urandom);
    end

    // Monitor: pop and compare on each new result, then check it is held
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", x_pos);
                end else begin
                    cur = sbq.pop_front();
                    chk("x_pos", 64'(x_pos), cur.res);
                    chk("sign_out", 64'(sign_out), 64'(cur.sgn));
                    chk("ovf", 64'(ovf), 64'(cur.ov));
                    chk("latency", 64'(cyc - cur.acc), 64'(NC));
                end
            end else begin
                chk("hold_x_pos", 64'(x_pos), cur.res);
                chk("hold_ovf", 64'(ovf), 64'(cur.ov));
                chk("done_in_ready", 64'(in_ready), 64'd0);
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Offer one operand to the main instance; call at #1 after an edge
    task automatic send(input logic [W-1:0] x, input logic [1:0] m);
        logic [65:0] r;
        int n;
        n = 0;
        in_valid = 1'b1;
        x_in     = x;
        mode_in  = m;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        r = ref_model(64'(x), m, W);
        sbq.push_back('{r[63:0], r[64], r[65], cyc});
        in_valid = 1'b0;
        x_in     = W'($urandom);
        mode_in  = 2'($urandom);
    endtask

    task automatic run8(input logic [7:0] x, input logic [1:0] m);
        logic [65:0] r;
        int n;
        n = 0;
        a_x = x; a_m = m; a_iv = 1'b1;
        while (!a_ir && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        a_iv = 1'b0;
        a_x  = 8'($urandom);
        n = 0;
        while (!a_ov && n < 100) begin @(posedge clk); #1; n++; end
        r = ref_model(64'(x), m, 8);
        chk("w8_latency", 64'(n), 64'd8);
        chk("w8_x_pos", 64'(a_xp), r[63:0]);
        chk("w8_sign", 64'(a_s), 64'(r[64]));
        chk("w8_ovf", 64'(a_ovf), 64'(r[65]));
        @(posedge clk); #1;
    endtask

    task automatic run32(input logic [31:0] x, input logic [1:0] m);
        logic [65:0] r;
        int n;
        n = 0;
        b_x = x; b_m = m; b_iv = 1'b1;
        while (!b_ir && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        b_iv = 1'b0;
        b_x  = $urandom;
        n = 0;
        while (!b_ov && n < 100) begin @(posedge clk); #1; n++; end
        r = ref_model(64'(x), m, 32);
        chk("w32_latency", 64'(n), 64'd1);
        chk("w32_x_pos", 64'(b_xp), r[63:0]);
        chk("w32_sign", 64'(b_s), 64'(r[64]));
        chk("w32_ovf", 64'(b_ovf), 64'(r[65]));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 200) begin @(posedge clk); #1; n++; end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending got %0d expected 0", sbq.size());
        end
    endtask

    logic [W-1:0] dir_x [7];
    logic [1:0]   dir_m [7];

    initial begin
        rst = 1'b0; in_valid = 1'b0; x_in = '0; mode_in = '0; out_ready = 1'b0;
        a_iv = 1'b0; a_x = '0; a_m = '0; b_iv = 1'b0; b_x = '0; b_m = '0;
        dir_x = '{23'h000001, 23'h000000, 23'h7FFFF6, 23'h400000, 23'h400005, 23'h400000, 23'h123456};
        dir_m = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_x_pos", 64'(x_pos), 64'd0);
        chk("rst_sign", 64'(sign_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed operands
        for (int i = 0; i < 7; i++) send(dir_x[i], dir_m[i]);
        drain();

        // Backpressure with a spurious in_valid pulse while DONE
        bp = 2;
        out_ready = 1'b0;
        send(23'h0ABCDE, 2'b01);
        for (int n = 0; n < 50 && !out_valid; n++) begin @(posedge clk); #1; end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin in_valid = 1'b1; x_in = 23'h055555; mode_in = 2'b01; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_out_valid_drop", 64'(out_valid), 64'd0);
        chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
        bp = 0;
        send(23'h000123, 2'b10);
        drain();
        repeat (NC + 3) @(posedge clk);
        #1;
        chk("no_spurious_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset during the second BUSY cycle
        send(23'h412345, 2'b01);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_x_pos", 64'(x_pos), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_sign", 64'(sign_out), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        sbq.delete();
        @(posedge clk); #1;
        chk("held_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        send(23'h000002, 2'b01);
        drain();

        // Random operands with random backpressure
        bp = 1;
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] x;
            case ($urandom_range(0, 4))
                0:       x = '0;
                1:       x = MNEG;
                2:       x = W'(1);
                3:       x = '1;
                default: x = W'($urandom);
            endcase
            send(x, 2'($urandom));
        end
        bp = 0;
        drain();

        // Other parameterisations
        run8(8'h80, 2'b01);
        for (int i = 0; i < 6; i++) run8(8'($urandom), 2'($urandom));
        run32(32'hFFFFFFFF, 2'b10);
        for (int i = 0; i < 6; i++) run32($urandom, 2'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nm_complement_seq.md
Name: nm_complement_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 23-bit conditional two's-complementer in the shift-multiplier datapath.
- Converts one operand per transaction, processing DIGIT bits per cycle with a carry register carried between cycles, so the adder width stays small for wide operands.
- Supports pass, negate, absolute-value and sign-magnitude-to-two's-complement modes.
- Valid/ready handshakes on both sides, so it sits between the operand register and the shift-add multiplier core.

Parameters:
- WIDTH, 23, operand/result width in bits; must be >= 2.
- DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= WIDTH.
- NCHUNK, derived as ceil(WIDTH/DIGIT), number of processing cycles; not user-set.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operand offered
- in_ready  output  1  block can accept an operand
- x_parallel  input  WIDTH  operand
- mode  input  2  00 pass, 01 negate, 10 abs, 11 sign-magnitude to two's complement
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- x_pos  output  WIDTH  result
- sign_out  output  1  sign of the original operand (x_parallel[WIDTH-1])
- ovf  output  1  result not representable (most-negative operand in negate or abs mode)

Behaviour:
- Reset: one clock; rst is asynchronous and active-low. While rst=0: state IDLE, in_ready=0, out_valid=0, x_pos=0, sign_out=0, ovf=0, internal counter, carry and operand registers=0. in_ready rises on the first clock edge after rst deasserts.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch operand, mode and sign_out. Set inv, then carry=inv, count=0, and go to BUSY.
  - inv per mode: 00 -> 0; 01 -> 1; 10 -> x[WIDTH-1]; 11 -> x[WIDTH-1], with the latched operand's MSB forced to 0 (magnitude only).
- BUSY:
  - in_ready=0.
  - Each cycle: slice k = operand[k*DIGIT +: DIGIT] XOR {DIGIT{inv}}; sum = slice + carry; write the low bits into x_pos slice k; carry = carry-out; count++.
  - The last slice is WIDTH-(NCHUNK-1)*DIGIT bits wide; its carry-out is discarded.
  - After NCHUNK cycles, go to DONE.
  - Every mode, including pass, takes the full NCHUNK cycles (fixed latency).
- DONE:
  - out_valid=1; x_pos, sign_out and ovf are held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - No same-cycle re-accept: in_ready rises one cycle later.
- Latency: out_valid is high NCHUNK cycles after the accept edge (3 for the defaults). Throughput is one operand per NCHUNK+2 cycles minimum.
- ovf=1 only in modes 01/10 when the operand is 1 followed by WIDTH-1 zeros. In that case x_pos equals the operand (wraps).
- Mode 11 with negative zero (MSB=1, rest 0): x_pos=0, ovf=0, sign_out=1.
- Mode 01 with operand 0: x_pos=0, ovf=0.
- in_valid while BUSY/DONE: ignored; the operand is not captured.
- mode and x_parallel changes after the accept edge: no effect.
- Reset mid-operation: the transaction is discarded, all outputs go immediately to reset values, and no partial result is ever presented.
- x_pos updates only in BUSY; its value during BUSY is don't-care to consumers (out_valid=0).

Optional Feature:
- Macro: NM_COMPLEMENT_SAT_EN.
- Defined: on an ovf case, x_pos saturates to 0 followed by WIDTH-1 ones (max positive); ovf is still asserted. The substitution is applied when entering DONE, with no added latency.
- Undefined: wrap behaviour (x_pos = most-negative value) and no saturation logic.

Test Plan:
- Defaults, mode 01, x=23'h000001 -> x_pos=23'h7FFFFF, ovf=0, sign_out=0, out_valid exactly 3 cycles after accept. Repeat with x=0 -> x_pos=0.
- Mode 10, x=23'h7FFFF6 -> x_pos=23'h00000A, sign_out=1. x=23'h400000 -> x_pos=23'h400000, ovf=1; with NM_COMPLEMENT_SAT_EN -> 23'h3FFFFF, ovf=1.
- Mode 11, x=23'h400005 -> x_pos=23'h7FFFFB, sign_out=1. x=23'h400000 -> x_pos=0, ovf=0. Mode 00, x=23'h123456 -> x_pos=23'h123456 after 3 cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> x_pos/ovf stable, in_ready=0, a second in_valid pulse is not captured. After out_ready=1, in_ready=1 on the next cycle and the next operand is processed correctly.
- Drive rst=0 asynchronously (mid-cycle) during the 2nd BUSY cycle -> out_valid/x_pos/ovf=0 immediately, in_ready=0 while rst=0. After release, a new op (mode 01, x=23'h000002) -> 23'h7FFFFE.
- Parameter sweep:
  - WIDTH=8, DIGIT=1: x=8'h80 mode 01 -> ovf=1, latency 8.
  - WIDTH=32, DIGIT=32: x=32'hFFFFFFFF mode 10 -> x_pos=1, latency 1.
  - Random operands and modes checked against a reference model.
